fetch_sequencer: RTL and testbench

Sequential controller that owns the program counter and drives the instruction-memory fetch handshake for the single-issue MIPS core. It sits between the combinational next-PC logic (branch/jump target selection) and instruction memory. It sequences each fetch, holds the fetched word for decode until accepted, and applies branch/jump redirects without breaking the memory handshake.

---
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
// Owns the program counter and sequences instruction-memory fetches for the
// single-issue core. Each fetched word is held for decode until it is
// accepted. Branch and jump redirects are applied without breaking an
// outstanding memory request.
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   imem_req/imem_addr           fetch request and word-aligned address
//   imem_ready/imem_rdata        request completion and returned word
//   instr_valid/instr/instr_pc   held instruction presented to decode
//   instr_accept                 decode consumes the held instruction
//   branch_taken/branch_target   resolved taken branch (1-cycle pulse)
//   jump_sel/jump_target         resolved jump (1-cycle pulse, beats branch)
//   fetch_count                  instructions accepted since reset
//
// state | meaning
// IDLE  | post-reset settle cycle, no request
// REQ   | request at pc outstanding
// DRAIN | old request outstanding, redirect pending
// HOLD  | fetched word held for decode
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_accept,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump_sel,
  input  logic [31:0] jump_target,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} stateT;

  stateT       state, stateNext;
  logic        rstDone;
  logic [31:0] pc, pcNext;
  logic [31:0] pending, pendingNext;
  logic        capture, countInc;
  logic        redirect;
  logic [31:0] rawTarget, target;

  assign redirect  = branch_taken | jump_sel;
  assign rawTarget = jump_sel ? jump_target : branch_target;
  assign target    = rawTarget & 32'hFFFF_FFFC;

  // The request address is the pc itself; pc only moves when no request
  // is outstanding or in the cycle the outstanding request completes.
  assign imem_req    = (state == REQ) || (state == DRAIN);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rstDone     <= 1'b0;
      pc          <= RESET_PC;
      pending     <= 32'h0;
      instr       <= 32'h0;
      instr_pc    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      state   <= stateNext;
      rstDone <= 1'b1;
      pc      <= pcNext;
      pending <= pendingNext;
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
      if (countInc) fetch_count <= fetch_count + 32'd1;
    end
  end

  always_comb begin
    stateNext   = state;
    pcNext      = pc;
    pendingNext = pending;
    capture     = 1'b0;
    countInc    = 1'b0;
    case (state)
      // rstDone keeps IDLE for the whole first cycle after reset release.
      IDLE: if (rstDone) stateNext = REQ;
      REQ: begin
        if (imem_ready) begin
          if (redirect) pcNext = target;
          else begin
            capture   = 1'b1;
            stateNext = HOLD;
          end
        end else if (redirect) begin
          pendingNext = target;
          stateNext   = DRAIN;
        end
      end
      DRAIN: begin
        // A redirect arriving with ready is newer than the pending one.
        if (imem_ready) begin
          pcNext    = redirect ? target : pending;
          stateNext = REQ;
        end else if (redirect) begin
          pendingNext = target;
        end
      end
      HOLD: begin
        if (redirect) begin
          pcNext    = target;
          stateNext = REQ;
        end else if (instr_accept) begin
          pcNext    = pc + 32'd4;
          countInc  = 1'b1;
          stateNext = REQ;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_accept;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump_sel;
  logic [31:0] jump_target;
  logic [31:0] fetch_count;

  fetch_sequencer #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_accept(instr_accept),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump_sel(jump_sel), .jump_target(jump_target),
    .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_3C3C;
  endfunction

  // Reference model: program-order view of fetching.
  int          mPhase;      // edges seen since reset release (saturates at 2)
  logic        mHeld;       // a fetched word is waiting for decode
  logic        mDiscard;    // outstanding fetch is stale, redirect queued
  logic [31:0] mDiscardT;
  logic [31:0] mPc;
  logic [31:0] mInstr, mInstrPc, mCount;

  function automatic void modelReset();
    mPhase = 0; mHeld = 0; mDiscard = 0; mDiscardT = 0;
    mPc = 0; mInstr = 0; mInstrPc = 0; mCount = 0;
  endfunction

  function automatic void modelStep(input logic r, input logic acc, input logic br,
                                    input logic [31:0] bt, input logic jp,
                                    input logic [31:0] jt);
    logic        redir;
    logic [31:0] tgt;
    redir = br | jp;
    tgt   = jp ? jt : bt;
    tgt[1:0] = 2'b00;
    if (mPhase < 2) mPhase++;
    else if (mHeld) begin
      if (redir) begin mPc = tgt; mHeld = 0; end
      else if (acc) begin mPc = mPc + 32'd4; mCount = mCount + 32'd1; mHeld = 0; end
    end else if (mDiscard) begin
      if (redir) mDiscardT = tgt;
      if (r) begin mPc = mDiscardT; mDiscard = 0; end
    end else if (r) begin
      if (redir) mPc = tgt;
      else begin mHeld = 1; mInstr = memWord(mPc); mInstrPc = mPc; end
    end else if (redir) begin
      mDiscard = 1; mDiscardT = tgt;
    end
  endfunction

  int memWait = -1;     // remaining wait cycles of the active request
  int fixedWait = -1;   // >=0 forces wait states, else random 0..3

  // One clock: compare at the negedge, drive inputs, step model at posedge.
  task automatic cyc(input logic acc, input logic br, input logic [31:0] bt,
                     input logic jp, input logic [31:0] jt);
    logic expReq;
    expReq = (mPhase == 2) && !mHeld;
    chkEq("req", imem_req, expReq);
    chkEq("addr", imem_addr, mPc);
    chkEq("valid", instr_valid, mHeld);
    chkEq("instr", instr, mInstr);
    chkEq("instrPc", instr_pc, mInstrPc);
    chkEq("count", fetch_count, mCount);
    if (imem_req && memWait < 0)
      memWait = (fixedWait >= 0) ? fixedWait : int'($urandom_range(0, 3));
    imem_ready    = imem_req && (memWait == 0);
    imem_rdata    = imem_ready ? memWord(imem_addr) : $urandom;
    instr_accept  = acc;
    branch_taken  = br;
    branch_target = bt;
    jump_sel      = jp;
    jump_target   = jt;
    @(posedge clk);
    modelStep(imem_ready, acc, br, bt, jp, jt);
    if (imem_ready) memWait = -1;
    else if (memWait > 0) memWait--;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    branch_taken = 1'b0;
    jump_sel = 1'b0;
    #1;
    chkEq("rstReq", imem_req, 0);
    chkEq("rstValid", instr_valid, 0);
    chkEq("rstAddr", imem_addr, 32'h0);
    chkEq("rstCount", fetch_count, 0);
    modelReset();
    memWait = -1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addrQ[$];
    logic [31:0] holdInstr, holdPc;
    int n, firstN;
    logic saw14;

    rst_n = 1'b0; imem_ready = 0; imem_rdata = 0; instr_accept = 0;
    branch_taken = 0; branch_target = 0; jump_sel = 0; jump_target = 0;
    modelReset();
    @(negedge clk);
    doReset();

    // Straight line, zero-wait memory, decode always accepting.
    fixedWait = 0;
    n = 0; firstN = -1;
    while (addrQ.size() < 4 && n < 20) begin
      if (imem_req) begin
        if (firstN < 0) firstN = n;
        addrQ.push_back(imem_addr);
      end
      cyc(1, 0, 0, 0, 0);
      n++;
    end
    chkEq("straightDone", addrQ.size(), 4);
    chkEq("firstReq", firstN, 2);
    for (int i = 0; i < addrQ.size(); i++) chkEq("seqAddr", addrQ[i], i * 4);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chkEq("count4", fetch_count, 4);

    // Decode stall on the word at 0x10, then branch away to 0x40.
    saw14 = 0;
    cyc(0, 0, 0, 0, 0);
    holdInstr = instr; holdPc = instr_pc;
    chkEq("holdPc", holdPc, 32'h10);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 0, 0);
      chkEq("stallValid", instr_valid, 1);
      chkEq("stallReq", imem_req, 0);
      chkEq("stallInstr", instr, holdInstr);
      chkEq("stallPc", instr_pc, holdPc);
      chkEq("stallCount", fetch_count, 4);
    end
    cyc(1, 1, 32'h40, 0, 0);   // accept loses to the branch
    chkEq("brValid", instr_valid, 0);
    chkEq("brAddr", imem_addr, 32'h40);
    chkEq("brCount", fetch_count, 4);
    if (imem_req && imem_addr == 32'h14) saw14 = 1;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chkEq("acceptNext", imem_addr, 32'h44);
    chkEq("no14", saw14, 0);

    // Redirects while a 3-wait-state fetch at 0x8 is outstanding.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h8);
    chkEq("jumpTo8", imem_addr, 32'h8);
    fixedWait = 3;
    cyc(0, 0, 0, 1, 32'h100);
    chkEq("drainAddrB", imem_addr, 32'h8);
    cyc(0, 1, 32'h200, 0, 0);
    chkEq("drainAddrC", imem_addr, 32'h8);
    chkEq("drainValid", instr_valid, 0);
    cyc(0, 0, 0, 0, 0);
    chkEq("drainAddrD", imem_addr, 32'h8);
    chkEq("drainReq", imem_req, 1);
    cyc(0, 0, 0, 0, 0);
    chkEq("newestWins", imem_addr, 32'h200);
    chkEq("afterDrainValid", instr_valid, 0);

    // Jump beats branch; low target bits are cleared.
    fixedWait = 0;
    cyc(0, 1, 32'h90, 1, 32'h80);
    chkEq("jumpWins", imem_addr, 32'h80);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 32'h9B, 0, 0);
    chkEq("brAlign", imem_addr, 32'h98);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h83);
    chkEq("jpAlign", imem_addr, 32'h80);

    // Async reset in the middle of a drain, then pc wrap.
    fixedWait = 3;
    cyc(0, 0, 0, 1, 32'h200);
    chkEq("inDrain", imem_req, 1);
    doReset();
    fixedWait = 0;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    chkEq("restartAddr", imem_addr, 32'h0);
    chkEq("restartReq", imem_req, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'hFFFF_FFFC);
    chkEq("topAddr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chkEq("wrapAddr", imem_addr, 32'h0);
    chkEq("wrapCount", fetch_count, 1);

    // Randomized traffic against the model.
    fixedWait = -1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) doReset();
      else cyc($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, $urandom,
               $urandom_range(0, 9) == 0, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
